dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports (A = pipeline MEM stage,
// B = debug/DMA) plus the data-memory side.
interface dmem_arbiter_if;
  logic        a_req_i;
  logic        a_we_i;
  logic [31:0] a_addr_i;
  logic [31:0] a_wdata_i;
  logic        a_ack_o;
  logic [31:0] a_rdata_o;

  logic        b_req_i;
  logic        b_we_i;
  logic [31:0] b_addr_i;
  logic [31:0] b_wdata_i;
  logic        b_ack_o;
  logic [31:0] b_rdata_o;

  logic        mem_wr_o;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
    output a_ack_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
    output b_ack_o, b_rdata_o,
    output mem_wr_o, mem_re_o, mem_addr_o, mem_data_o,
    input  mem_data_i
  );

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_wdata_i,
    input  a_ack_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_ack_o, b_rdata_o,
    input  mem_wr_o, mem_re_o, mem_addr_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, one access in flight (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (A wins).
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 32'd2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_arbiter_if.slave bus,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic        we_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        win_b_r;
  logic [31:0] rdata_a_r;
  logic [31:0] rdata_b_r;
  logic        ack_a_r;
  logic        ack_b_r;
  logic        mem_wr_r;
  logic        mem_re_r;
  logic        busy_r;
  logic        any_req_s;
  logic        grant_b_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
`ifdef DMEM_ARB_RR_EN
  logic        last_b_r;
`endif

  // Winner selection and the winner's request fields.
  always_comb begin
    any_req_s = bus.a_req_i | bus.b_req_i;
`ifdef DMEM_ARB_RR_EN
    if (bus.a_req_i && bus.b_req_i) begin
      grant_b_s = ~last_b_r;
    end else begin
      grant_b_s = bus.b_req_i;
    end
`else
    grant_b_s = bus.b_req_i & ~bus.a_req_i;
`endif
    if (grant_b_s) begin
      sel_we_s    = bus.b_we_i;
      sel_addr_s  = bus.b_addr_i;
      sel_wdata_s = bus.b_wdata_i;
    end else begin
      sel_we_s    = bus.a_we_i;
      sel_addr_s  = bus.a_addr_i;
      sel_wdata_s = bus.a_wdata_i;
    end
  end

  // Next-state logic; we_nxt_s lets the strobes be registered off the next state.
  always_comb begin
    state_nxt_s = state_r;
    we_nxt_s    = we_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ACCESS;
          we_nxt_s    = sel_we_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      mem_wr_r <= 1'b0;
      mem_re_r <= 1'b0;
      ack_a_r  <= 1'b0;
      ack_b_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      mem_wr_r <= (state_nxt_s == ST_ACCESS) & we_nxt_s;
      mem_re_r <= (state_nxt_s == ST_ACCESS) & ~we_nxt_s;
      ack_a_r  <= (state_nxt_s == ST_RESP) & ~win_b_r;
      ack_b_r  <= (state_nxt_s == ST_RESP) & win_b_r;
    end
  end

  // Request latch, latency counter and per-port read-data capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      win_b_r   <= 1'b0;
      rdata_a_r <= 32'd0;
      rdata_b_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            win_b_r <= grant_b_s;
            cnt_r   <= CNT_INIT;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (!we_r) begin
            if (win_b_r) begin
              rdata_b_r <= bus.mem_data_i;
            end else begin
              rdata_a_r <= bus.mem_data_i;
            end
          end
        end
        ST_RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the last granted port so simultaneous requests alternate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_r <= 1'b1;
    end else if (state_r == ST_IDLE && any_req_s) begin
      last_b_r <= grant_b_s;
    end
  end
`endif

  assign bus.mem_wr_o   = mem_wr_r;
  assign bus.mem_re_o   = mem_re_r;
  assign bus.mem_addr_o = addr_r;
  assign bus.mem_data_o = wdata_r;
  assign bus.a_ack_o    = ack_a_r;
  assign bus.b_ack_o    = ack_b_r;
  assign bus.a_rdata_o  = rdata_a_r;
  assign bus.b_rdata_o  = rdata_b_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
  localparam int L = 2;

  logic clk;
  logic rst;
  logic busy;
  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_LAT(L)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Data memory emulation: 64 words, combinational read.
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  assign bus.mem_data_i = mem[bus.mem_addr_o[7:2]];
  always @(posedge clk) begin
    if (bus.mem_wr_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_data_o;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  // Transaction-level model state.
  logic [31:0] model_mem [0:63];
  bit          m_valid = 1'b0;
  bit          m_active;
  bit          m_port_b;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata_a, m_rdata_b;
  int          m_start;
  int          cyc = 0;
`ifdef DMEM_ARB_RR_EN
  bit          m_last_b;
`endif
  int re_cnt = 0, wr_cnt = 0, ack_a_cnt = 0, ack_b_cnt = 0;

  // Per-cycle compare against the model, then advance the model to the next cycle.
  always @(negedge clk) begin
    int  p;
    bit  in_acc, in_resp;
    cyc++;
    p = cyc - m_start;
    if (m_valid) begin
      in_acc  = m_active && p >= 1 && p <= L;
      in_resp = m_active && p == L + 1;
      chk1("mem_wr_o", bus.mem_wr_o, in_acc && m_we);
      chk1("mem_re_o", bus.mem_re_o, in_acc && !m_we);
      chk1("a_ack_o", bus.a_ack_o, in_resp && !m_port_b);
      chk1("b_ack_o", bus.b_ack_o, in_resp && m_port_b);
      chk1("busy_o", busy, m_active);
      chk("mem_addr_o", bus.mem_addr_o, m_addr);
      chk("mem_data_o", bus.mem_data_o, m_wdata);
      chk("a_rdata_o", bus.a_rdata_o, m_rdata_a);
      chk("b_rdata_o", bus.b_rdata_o, m_rdata_b);
    end
    if (bus.mem_re_o) re_cnt++;
    if (bus.mem_wr_o) wr_cnt++;
    if (bus.a_ack_o) ack_a_cnt++;
    if (bus.b_ack_o) ack_b_cnt++;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_port_b = 1'b0; m_we = 1'b0;
      m_addr = 32'd0; m_wdata = 32'd0; m_rdata_a = 32'd0; m_rdata_b = 32'd0;
`ifdef DMEM_ARB_RR_EN
      m_last_b = 1'b1;
`endif
    end else if (m_valid) begin
      if (m_active && p == L) begin
        if (m_we) model_mem[m_addr[7:2]] = m_wdata;
        else if (m_port_b) m_rdata_b = model_mem[m_addr[7:2]];
        else m_rdata_a = model_mem[m_addr[7:2]];
      end
      if (m_active && p == L + 1) begin
        m_active = 1'b0;
      end else if (!m_active && (bus.a_req_i || bus.b_req_i)) begin
`ifdef DMEM_ARB_RR_EN
        m_port_b = (bus.a_req_i && bus.b_req_i) ? !m_last_b : bus.b_req_i;
        m_last_b = m_port_b;
`else
        m_port_b = !bus.a_req_i;
`endif
        m_active = 1'b1;
        m_start  = cyc;
        m_we     = m_port_b ? bus.b_we_i : bus.a_we_i;
        m_addr   = m_port_b ? bus.b_addr_i : bus.a_addr_i;
        m_wdata  = m_port_b ? bus.b_wdata_i : bus.a_wdata_i;
      end
    end
    if (pre_we) model_mem[pre_idx] = pre_val;
  end

  task automatic access(input bit is_b, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    @(posedge clk); #1;
    if (is_b) begin
      bus.b_req_i = 1'b1; bus.b_we_i = we; bus.b_addr_i = addr; bus.b_wdata_i = wdata;
    end else begin
      bus.a_req_i = 1'b1; bus.a_we_i = we; bus.a_addr_i = addr; bus.a_wdata_i = wdata;
    end
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (is_b ? bus.b_ack_o : bus.a_ack_o) lat = n;
    end
    if (lat < 0) chk("ack_timeout", 32'hFFFFFFFF, 32'd0);
    @(posedge clk); #1;
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, snap, snap2;
    int ack_n [0:7];
    bit ack_b [0:7];
    int nack;
    rst = 1'b1; pre_we = 1'b0; pre_idx = 6'd0; pre_val = 32'd0;
    bus.a_req_i = 1'b0; bus.a_we_i = 1'b0; bus.a_addr_i = 32'd0; bus.a_wdata_i = 32'd0;
    bus.b_req_i = 1'b0; bus.b_we_i = 1'b0; bus.b_addr_i = 32'd0; bus.b_wdata_i = 32'd0;
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = 6'd2; pre_val = 32'h11223344;
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(negedge clk);
    chk1("reset_busy", busy, 1'b0);
    chk("reset_addr", bus.mem_addr_o, 32'd0);
    chk1("reset_re", bus.mem_re_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A read of 0x8 holding 0x11223344.
    snap = re_cnt;
    access(1'b0, 1'b0, 32'h8, 32'd0, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_re_cycles", 32'(re_cnt - snap), 32'd2);
    chk("rd_data", bus.a_rdata_o, 32'h11223344);

    // B write 0xDEADBEEF to 0x10, then A read it back.
    snap = wr_cnt; snap2 = ack_b_cnt;
    access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_we_cycles", 32'(wr_cnt - snap), 32'd2);
    chk("wr_b_acks", 32'(ack_b_cnt - snap2), 32'd1);
    access(1'b0, 1'b0, 32'h10, 32'd0, lat);
    chk("rd_back", bus.a_rdata_o, 32'hDEADBEEF);
    chk("b_rdata_kept", bus.b_rdata_o, 32'd0);
    access(1'b0, 1'b1, 32'h14, 32'h0BADF00D, lat);
    chk("wr_keeps_rdata", bus.a_rdata_o, 32'hDEADBEEF);

    // Reset during an A write's ACCESS phase.
    snap = ack_a_cnt;
    @(posedge clk); #1;
    bus.a_req_i = 1'b1; bus.a_we_i = 1'b1; bus.a_addr_i = 32'h20; bus.a_wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_in_access", bus.mem_wr_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; bus.a_req_i = 1'b0;
    @(negedge clk);
    chk1("abort_wr_off", bus.mem_wr_o, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_addr", bus.mem_addr_o, 32'd0);
    chk("abort_data", bus.mem_data_o, 32'd0);
    chk("abort_rdata", bus.a_rdata_o, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_ack", 32'(ack_a_cnt - snap), 32'd0);

    // Both ports requesting continuously.
    nack = 0;
    @(posedge clk); #1;
    bus.a_req_i = 1'b1; bus.a_we_i = 1'b0; bus.a_addr_i = 32'h8; bus.a_wdata_i = 32'd0;
    bus.b_req_i = 1'b1; bus.b_we_i = 1'b0; bus.b_addr_i = 32'h10; bus.b_wdata_i = 32'd0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if ((bus.a_ack_o || bus.b_ack_o) && nack < 8) begin
        ack_n[nack] = n; ack_b[nack] = bus.b_ack_o; nack++;
      end
    end
    @(posedge clk); #1;
    bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk1("contend_idle", busy, 1'b0);
    chk("contend_acks", 32'(nack), 32'd4);
    for (int k = 0; k < 4 && k < nack; k++) begin
      chk("contend_ack_cycle", 32'(ack_n[k]), 32'(3 + 4 * k));
`ifdef DMEM_ARB_RR_EN
      chk1("contend_ack_port", ack_b[k], (k % 2) == 1);
`else
      chk1("contend_ack_port", ack_b[k], 1'b0);
`endif
    end
    chk("contend_a_rdata", bus.a_rdata_o, 32'h11223344);
`ifdef DMEM_ARB_RR_EN
    chk("contend_b_rdata", bus.b_rdata_o, 32'hDEADBEEF);
`else
    chk("contend_b_rdata", bus.b_rdata_o, 32'd0);
`endif

    // Normal B read afterwards.
    access(1'b1, 1'b0, 32'h10, 32'd0, lat);
    chk("post_latency", 32'(lat), 32'd3);
    chk("post_b_rdata", bus.b_rdata_o, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
